// File: rtl/mvau_weight_fetch.sv
// Weight fetch for an MVAU PE: streams the weight memory in address order
// through a 2-entry skid FIFO, keeping at most two words buffered or in flight.
module mvau_weight_fetch #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    en,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_in,
  output logic [SIMD*TW-1:0]      out_wgt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int DW = SIMD * TW;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  logic [WMEM_ADDR_BW-1:0] addr_reg, addr_next;
  logic                    inflight_reg;
  logic                    inflight_last_reg;
  logic                    rd_ptr_reg;
  logic                    wr_ptr_reg;
  logic [1:0]              count_reg, count_next;
  logic [2:0]              occ_after_pop;
  logic                    push, pop, issue;
  logic [DW-1:0]           entry_data [2];
  logic                    entry_last [2];

  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid & out_ready;
  // Memory read latency is one cycle, so an in-flight read always lands now.
  assign push      = inflight_reg & ~rst;

  // Reserve a slot for every word already buffered or on its way back.
  assign occ_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue         = ~rst & en & (occ_after_pop < 3'd2);

  always_comb begin
    addr_next  = addr_reg;
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
    if (issue) begin
      if (addr_reg == LAST_ADDR) addr_next = '0;
      else                       addr_next = addr_reg + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      addr_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
    end else begin
      addr_reg     <= addr_next;
      inflight_reg <= issue;
      if (issue) inflight_last_reg <= (addr_reg == LAST_ADDR);
      if (push)  wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic IDX = 1'(gi);
      logic [DW-1:0] data_reg;
      logic          last_reg;

      always_ff @(posedge aclk) begin
        if (push && (wr_ptr_reg == IDX)) begin
          data_reg <= wmem_in;
          last_reg <= inflight_last_reg;
        end
      end

      assign entry_data[gi] = data_reg;
      assign entry_last[gi] = last_reg;
    end
  endgenerate

  assign wmem_addr = addr_reg;
  assign out_wgt   = entry_data[rd_ptr_reg];
  assign out_last  = out_valid & entry_last[rd_ptr_reg];

endmodule
